// File: rtl/sn76489_pkg.sv
// Shared constants and types for the SN76489 register file.
package sn76489_pkg;

    // Latched register index: bits 2:1 = channel, bit 0 = 1 for attenuation.
    localparam logic [2:0] REG_TONE0 = 3'b000;
    localparam logic [2:0] REG_ATT0  = 3'b001;
    localparam logic [2:0] REG_TONE1 = 3'b010;
    localparam logic [2:0] REG_ATT1  = 3'b011;
    localparam logic [2:0] REG_TONE2 = 3'b100;
    localparam logic [2:0] REG_ATT2  = 3'b101;
    localparam logic [2:0] REG_NOISE = 3'b110;
    localparam logic [2:0] REG_ATT3  = 3'b111;

    // Attenuation value meaning "channel silent".
    localparam logic [3:0] ATT_OFF = 4'hF;

    localparam int DEFAULT_CLK_DIV     = 16;
    localparam int DEFAULT_BUSY_CYCLES = 32;

    // Write-acceptance handshake states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } busy_state_t;

    // Index of the register selected by channel number and type.
    function automatic logic [2:0] reg_index(input logic [1:0] channel, input logic is_att);
        return {channel, is_att};
    endfunction

endpackage

// File: rtl/sn76489_clock_divider.sv
// Free-running divider producing a one-cycle enable strobe every CLK_DIV clocks.
module sn76489_clock_divider
    import sn76489_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic enable
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_reg;

    // Counter wraps naturally because CLK_DIV is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign enable = (cnt_reg == LAST);

endmodule

// File: rtl/sn76489_register_file.sv
// SN76489 programmer-visible registers: latch/data byte decode, busy handshake,
// and the divide-by-CLK_DIV enable strobe for the downstream generators.
module sn76489_register_file
    import sn76489_pkg::*;
#(
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int BUSY_CYCLES = DEFAULT_BUSY_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       enable,
    output logic [9:0] tone0_n,
    output logic [9:0] tone1_n,
    output logic [9:0] tone2_n,
    output logic [3:0] att0,
    output logic [3:0] att1,
    output logic [3:0] att2,
    output logic [3:0] att3,
    output logic [2:0] noise_ctrl,
    output logic       noise_reset
);

    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES - 1);

    busy_state_t     state_reg, state_next;
    logic [BW-1:0]   busy_cnt_reg, busy_cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [2:0][9:0] tone_reg, tone_next;
    logic [3:0][3:0] att_reg, att_next;
    logic [2:0]      noise_ctrl_reg, noise_ctrl_next;
    logic            noise_reset_reg, noise_reset_next;

    logic            accept;
    logic            is_latch;
    logic [2:0]      idx_eff;
    logic            noise_hit;

    // A latch byte retargets the write immediately; a data byte uses the held index.
    assign accept    = wr && (state_reg == ST_IDLE);
    assign is_latch  = data[7];
    assign idx_eff   = is_latch ? data[6:4] : idx_reg;
    assign noise_hit = accept && (idx_eff == REG_NOISE);

    assign idx_next         = (accept && is_latch) ? data[6:4] : idx_reg;
    assign noise_ctrl_next  = noise_hit ? data[2:0] : noise_ctrl_reg;
    assign noise_reset_next = noise_hit;

    // Tone periods: latch bytes load the low nibble, data bytes the upper six bits.
    for (genvar gi = 0; gi < 3; gi++) begin : g_tone
        localparam logic [2:0] IDX = reg_index(2'(gi), 1'b0);
        assign tone_next[gi] = !(accept && (idx_eff == IDX)) ? tone_reg[gi] :
                               is_latch ? {tone_reg[gi][9:4], data[3:0]} :
                                          {data[5:0], tone_reg[gi][3:0]};
    end

    // Attenuations: both byte kinds load the full nibble.
    for (genvar gi = 0; gi < 4; gi++) begin : g_att
        localparam logic [2:0] IDX = reg_index(2'(gi), 1'b1);
        assign att_next[gi] = (accept && (idx_eff == IDX)) ? data[3:0] : att_reg[gi];
    end

    // Busy FSM next state: ready stays low for exactly BUSY_CYCLES cycles.
    always_comb begin
        state_next    = state_reg;
        busy_cnt_next = busy_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wr) begin
                    state_next    = ST_BUSY;
                    busy_cnt_next = BUSY_LOAD;
                end
            end
            ST_BUSY: begin
                if (busy_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    busy_cnt_next = busy_cnt_reg - BW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and register update; reset forces idle and power-up values at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            busy_cnt_reg    <= '0;
            idx_reg         <= REG_TONE0;
            tone_reg        <= '0;
            att_reg         <= {4{ATT_OFF}};
            noise_ctrl_reg  <= '0;
            noise_reset_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            busy_cnt_reg    <= busy_cnt_next;
            idx_reg         <= idx_next;
            tone_reg        <= tone_next;
            att_reg         <= att_next;
            noise_ctrl_reg  <= noise_ctrl_next;
            noise_reset_reg <= noise_reset_next;
        end
    end

    sn76489_clock_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_clock_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable)
    );

    assign ready       = (state_reg == ST_IDLE);
    assign tone0_n     = tone_reg[0];
    assign tone1_n     = tone_reg[1];
    assign tone2_n     = tone_reg[2];
    assign att0        = att_reg[0];
    assign att1        = att_reg[1];
    assign att2        = att_reg[2];
    assign att3        = att_reg[3];
    assign noise_ctrl  = noise_ctrl_reg;
    assign noise_reset = noise_reset_reg;

endmodule

// File: tb/tb_sn76489_register_file.sv
// Scoreboard bench for sn76489_register_file: driver pushes expected register
// snapshots, a monitor pops one each time the DUT accepts a write.
module tb_sn76489_register_file;

    localparam int BUSY = 32;
    localparam int DIV  = 16;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic [7:0] data;
    logic       ready;
    logic       enable;
    logic [9:0] tone0_n, tone1_n, tone2_n;
    logic [3:0] att0, att1, att2, att3;
    logic [2:0] noise_ctrl;
    logic       noise_reset;

    sn76489_register_file #(
        .CLK_DIV     (DIV),
        .BUSY_CYCLES (BUSY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .data        (data),
        .ready       (ready),
        .enable      (enable),
        .tone0_n     (tone0_n),
        .tone1_n     (tone1_n),
        .tone2_n     (tone2_n),
        .att0        (att0),
        .att1        (att1),
        .att2        (att2),
        .att3        (att3),
        .noise_ctrl  (noise_ctrl),
        .noise_reset (noise_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] b;
        logic [9:0] t0, t1, t2;
        logic [3:0] a0, a1, a2, a3;
        logic [2:0] nc;
        logic       nr;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    bit mon_en     = 1'b0;
    int div_model  = 0;

    // Reference model state: plain arrays indexed by channel.
    logic [9:0] m_tone [3];
    logic [3:0] m_att  [4];
    logic [2:0] m_noise;
    logic [2:0] m_idx;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
        for (int i = 0; i < 4; i++) m_att[i] = 4'hF;
        m_noise = 3'd0;
        m_idx   = 3'd0;
    endtask

    // Apply one accepted byte per the latch/data protocol.
    task automatic model_apply(input logic [7:0] b, output logic nr);
        int ch;
        nr = 1'b0;
        if (b[7]) m_idx = b[6:4];
        ch = int'(m_idx) / 2;
        if (m_idx % 2 == 1) begin
            m_att[ch] = b[3:0];
        end else if (ch == 3) begin
            m_noise = b[2:0];
            nr = 1'b1;
        end else if (b[7]) begin
            m_tone[ch] = (m_tone[ch] / 16) * 16 + 10'(b % 16);
        end else begin
            m_tone[ch] = 10'(int'(b % 64) * 16) + (m_tone[ch] % 16);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        chk("ready_timeout", 0, 1);
    endtask

    // Issue a write the bench knows will be accepted; record expectation.
    task automatic write_byte(input logic [7:0] b);
        exp_t e;
        logic nr;
        wait_ready();
        wr   = 1'b1;
        data = b;
        model_apply(b, nr);
        e.b  = b;
        e.t0 = m_tone[0]; e.t1 = m_tone[1]; e.t2 = m_tone[2];
        e.a0 = m_att[0];  e.a1 = m_att[1];  e.a2 = m_att[2];  e.a3 = m_att[3];
        e.nc = m_noise;
        e.nr = nr;
        exp_q.push_back(e);
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Pulse wr while the DUT is known to be busy; must have no effect.
    task automatic write_ignored(input logic [7:0] b);
        wr   = 1'b1;
        data = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_tone0"}, tone0_n, 0);
        chk({tag, "_tone1"}, tone1_n, 0);
        chk({tag, "_tone2"}, tone2_n, 0);
        chk({tag, "_att0"}, att0, 4'hF);
        chk({tag, "_att1"}, att1, 4'hF);
        chk({tag, "_att2"}, att2, 4'hF);
        chk({tag, "_att3"}, att3, 4'hF);
        chk({tag, "_noise_ctrl"}, noise_ctrl, 0);
        chk({tag, "_noise_reset"}, noise_reset, 0);
    endtask

    // Monitor: an accepted write shows up as ready falling; pop and compare.
    initial begin
        bit prev_ready = 1'b1;
        int busy_len   = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_ready = 1'b1;
                busy_len   = 0;
            end else begin
                if (prev_ready && !ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_accept", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tone0_n", tone0_n, e.t0);
                        chk("tone1_n", tone1_n, e.t1);
                        chk("tone2_n", tone2_n, e.t2);
                        chk("att0", att0, e.a0);
                        chk("att1", att1, e.a1);
                        chk("att2", att2, e.a2);
                        chk("att3", att3, e.a3);
                        chk("noise_ctrl", noise_ctrl, e.nc);
                        chk("noise_reset_pulse", noise_reset, e.nr);
                        $display("txn byte=0x%02h tone=%03h/%03h/%03h att=%h%h%h%h noise=%0d nr=%0b",
                                 e.b, tone0_n, tone1_n, tone2_n, att0, att1, att2, att3,
                                 noise_ctrl, noise_reset);
                    end
                    busy_len = 1;
                end else begin
                    if (noise_reset) chk("noise_reset_idle", noise_reset, 0);
                    if (!ready) begin
                        busy_len++;
                    end else if (busy_len != 0) begin
                        chk("busy_length", busy_len, BUSY);
                        busy_len = 0;
                    end
                end
                prev_ready = ready;
            end
        end
    end

    // Divider reference: cycles since reset release modulo DIV.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) div_model = 0;
            else div_model = (div_model + 1) % DIV;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                if (enable) chk("enable_in_reset", enable, 0);
            end else if (div_model == DIV - 1) begin
                chk("enable_strobe", enable, 1);
            end else if (enable) begin
                chk("enable_quiet", enable, 0);
            end
        end
    end

    initial begin
        logic [7:0] b;
        reset_n = 1'b0;
        wr      = 1'b0;
        data    = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        chk("reset_enable", enable, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Tone: latch low nibble then data byte for upper bits.
        write_byte(8'h8E);
        write_byte(8'h3F);
        chk("tone0_direct", tone0_n, 10'h3FE);

        // Attenuation writes.
        write_byte(8'hD1);
        chk("att2_direct", att2, 1);
        write_byte(8'hB0);
        write_byte(8'h03);
        chk("att1_direct", att1, 3);
        chk("tone1_kept", tone1_n, 0);

        // Noise control with reset pulses.
        write_byte(8'hE5);
        chk("noise_direct_a", noise_ctrl, 5);
        write_byte(8'h02);
        chk("noise_direct_b", noise_ctrl, 2);

        // Write while busy must be ignored.
        write_byte(8'h9F);
        repeat (9) @(negedge clk);
        write_ignored(8'h90);
        wait_ready();
        chk("att0_after_ignored", att0, 4'hF);

        // Asynchronous reset in the middle of a busy window.
        write_byte(8'h85);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        write_byte(8'hC7);
        chk("post_reset_tone2", tone2_n, 7);

        // Randomised traffic with occasional ignored writes during busy.
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            write_byte(b);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 25)) @(negedge clk);
                write_ignored(8'($urandom_range(0, 255)));
            end
        end

        wait_ready();
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sn76489_register_file.md
# sn76489_register_file

Programmer-visible register file of the SN76489 PSG. It decodes CPU byte writes using the latch/data protocol and holds the three 10-bit tone periods, the four attenuations and the noise control. It also generates the divide-by-16 `enable` strobe. Its outputs drive `n`/`att`/`enable` of the three `sn76489_tone_generator` instances and the noise generator directly downstream.

## Interface
- `CLK_DIV`, 16: period of the `enable` strobe in `clk` cycles (power of two, ≥2).
- `BUSY_CYCLES`, 32: `clk` cycles `ready` stays low after an accepted write.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr` in 1: write strobe, sampled on `clk` rising edge.
- `data` in 8: CPU byte.
- `ready` out 1: high when a write will be accepted.
- `enable` out 1: one-cycle strobe every `CLK_DIV` cycles.
- `tone0_n`, `tone1_n`, `tone2_n` out 10 each: tone periods N.
- `att0`, `att1`, `att2`, `att3` out 4 each: attenuation; channel 3 is noise. 4'hF = off, 4'h0 = full.
- `noise_ctrl` out 3: noise feedback/shift-rate select.
- `noise_reset` out 1: one-cycle pulse on any write to the noise register.

## Operation
- **Reset values:**
  - All `toneX_n` = 0, all `attX` = 4'hF, `noise_ctrl` = 0, `noise_reset` = 0.
  - `ready` = 1, `enable` = 0, divider counter = 0.
  - Latched register index = 3'b000 (tone0).
- **Acceptance:** a write is accepted when `wr`=1 and `ready`=1 at a rising edge. `wr` while `ready`=0 is ignored, with no state change.
- **Latch byte** (`data[7]`=1):
  - Set the latched index to `data[6:4]`: bits 6:5 select the channel, bit 4 selects the type (1 = attenuation, 0 = tone/noise).
  - Tone: `n[3:0]` ← `data[3:0]`; `n[9:4]` is kept.
  - Attenuation: `att` ← `data[3:0]`.
  - Noise (index 3'b110): `noise_ctrl` ← `data[2:0]`.
- **Data byte** (`data[7]`=0): acts on the latched register.
  - Tone: `n[9:4]` ← `data[5:0]`.
  - Attenuation: `att` ← `data[3:0]`.
  - Noise: `noise_ctrl` ← `data[2:0]`.
  - The latched index is unchanged.
- **Noise reset:** any accepted write that updates `noise_ctrl` (latch or data byte) asserts `noise_reset` for exactly one cycle.
- **Busy FSM:**
  - States: IDLE (`ready`=1) and BUSY (`ready`=0).
  - IDLE→BUSY on an accepted write; a busy counter loads `BUSY_CYCLES`−1.
  - BUSY decrements the counter each cycle and returns to IDLE when it reaches 0 (counter zero at the edge → IDLE).
  - `ready` is low for exactly `BUSY_CYCLES` cycles.
- **Divider:** a free-running `log2(CLK_DIV)`-bit counter that wraps. `enable` = 1 while the counter = `CLK_DIV`−1. The divider is independent of writes.

## Timing
- Register outputs, `noise_reset` and `ready` are all registered. They change at the accepting edge and are visible in the following cycle.
- Back-to-back writes are possible no sooner than `BUSY_CYCLES`+1 edges apart.
- First `enable` after reset release is high during cycle 16 (counter 15). It then recurs every 16 cycles.
- A write coinciding with `enable` updates registers normally. The downstream generator samples the old values on that strobe.
- Asserting `reset_n` low mid-BUSY forces IDLE, `ready`=1 and all reset values immediately, without waiting for a clock.
- `noise_reset` is never high for two consecutive cycles, because writes are ≥`BUSY_CYCLES` apart.

## Structure
- **`sn76489_pkg`:**
  - Register-index constants: TONE0=3'b000, ATT0=3'b001, TONE1=3'b010, ATT1=3'b011, TONE2=3'b100, ATT2=3'b101, NOISE=3'b110, ATT3=3'b111.
  - `ATT_OFF`=4'hF.
  - Default `CLK_DIV`.
- **Sub-module `sn76489_clock_divider`:** takes `clk`, `reset_n` and `CLK_DIV`, produces `enable`. Decode and busy FSM stay in the top module.

## Test plan
- **Reset:** release `reset_n` → all `att`=F, tone periods 0, `ready`=1. `enable` first high 16 cycles after release, then every 16 cycles.
- **Tone write:** write 0x8E, wait for `ready`, write 0x3F → `tone0_n`=0x3FE. `ready` is low for exactly 32 cycles after each write.
- **Attenuation writes:** 0xD1 → `att2`=1. Then 0xB0 followed by data byte 0x03 → `att1`=3, with `tone1_n` unchanged.
- **Noise write:** 0xE5 → `noise_ctrl`=5 and `noise_reset` high for one cycle. A later data byte 0x02 → `noise_ctrl`=2 with a second one-cycle pulse.
- **Write while busy:** write 0x9F, then pulse `wr` with 0x90 ten cycles later → `att0` stays F and the busy window is not extended.
- **Reset during busy:** assert `reset_n` low during BUSY → `ready`=1 asynchronously and registers return to reset values. After release, a new write is accepted normally.
